coin_change_payout: RTL and testbench

Pays out the change amount produced by the coffee-machine FSM as a sequence of physical coins to a coin hopper. Coin encoding is shared with the vending side: 01 = 1, 10 = 2, 11 = 3.
- Keeps a per-denomination stock of coins.
- Selects coins greedily, largest first.
- Issues one coin at a time over a valid/ack handshake.
- Reports completion, or a shortfall when stock runs out.

---
 rtl/coffee_pkg.sv | 29 ++
 rtl/coin_stock_counter.sv | 33 +++
 rtl/coin_change_payout.sv | 122 ++++++++++++
 tb/tb_coin_change_payout.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared coffee-machine definitions: coin encodings, coin value decode, payout FSM states.
package coffee_pkg;

  localparam int unsigned COIN_W = 2;
  localparam int unsigned AMT_W  = 4;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_1    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_2    = 2'b10;
  localparam logic [COIN_W-1:0] COIN_3    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE,
    ST_FAULT
  } payout_state_e;

  function automatic logic [AMT_W-1:0] coin_value(input logic [COIN_W-1:0] coin);
    case (coin)
      COIN_1:  return AMT_W'(1);
      COIN_2:  return AMT_W'(2);
      COIN_3:  return AMT_W'(3);
      default: return AMT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/coin_stock_counter.sv
// Per-denomination coin stock: saturating increment, decrement, inc+dec holds.
module coin_stock_counter #(
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [STOCK_W-1:0] count_o
);

  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  logic [STOCK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != STOCK_MAX)) begin
      count_d = count_q + STOCK_W'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - STOCK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= STOCK_W'(INIT_STOCK);
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/coin_change_payout.sv
// Pays a change amount out as coins, largest denomination first, one coin per
// valid/ack handshake, reporting done or a stock shortfall.
module coin_change_payout
  import coffee_pkg::*;
#(
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amount,
  output logic               req_ready,
  output logic [COIN_W-1:0]  coin_out,
  output logic               coin_valid,
  input  logic               coin_ack,
  output logic               done,
  output logic               fault,
  output logic [AMT_W-1:0]   short_amt,
  input  logic               refill_valid,
  input  logic [COIN_W-1:0]  refill_denom,
  output logic [STOCK_W-1:0] stock1,
  output logic [STOCK_W-1:0] stock2,
  output logic [STOCK_W-1:0] stock3
);

  payout_state_e     state_q, state_d;
  logic [AMT_W-1:0]  remaining_q, remaining_d;
  logic [COIN_W-1:0] coin_q, coin_d;
  logic              coin_valid_q, done_q, fault_q, req_ready_q;
  logic [2:0]        inc, dec;

  assign inc[0] = refill_valid && (refill_denom == COIN_1);
  assign inc[1] = refill_valid && (refill_denom == COIN_2);
  assign inc[2] = refill_valid && (refill_denom == COIN_3);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    dec         = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_amount == AMT_W'(0)) begin
            remaining_d = AMT_W'(0);
            state_d     = ST_DONE;
          end else begin
            remaining_d = req_amount;
            state_d     = ST_SELECT;
          end
        end
      end
      // Greedy pick; no backtracking even if another combination would fit.
      ST_SELECT: begin
        state_d = ST_ISSUE;
        if ((stock3 != '0) && (remaining_q >= AMT_W'(3)))      coin_d = COIN_3;
        else if ((stock2 != '0) && (remaining_q >= AMT_W'(2))) coin_d = COIN_2;
        else if ((stock1 != '0) && (remaining_q >= AMT_W'(1))) coin_d = COIN_1;
        else                                                    state_d = ST_FAULT;
      end
      ST_ISSUE: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_q);
          coin_d      = COIN_NONE;
          case (coin_q)
            COIN_1:  dec = 3'b001;
            COIN_2:  dec = 3'b010;
            COIN_3:  dec = 3'b100;
            default: dec = 3'b000;
          endcase
          state_d = (remaining_d == AMT_W'(0)) ? ST_DONE : ST_SELECT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: begin
        remaining_d = AMT_W'(0);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      coin_q       <= COIN_NONE;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_q       <= coin_d;
      coin_valid_q <= (state_d == ST_ISSUE);
      done_q       <= (state_d == ST_DONE);
      fault_q      <= (state_d == ST_FAULT);
      req_ready_q  <= (state_d == ST_IDLE);
    end
  end

  coin_stock_counter #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock1 (
    .clk(clk), .reset(reset), .inc_i(inc[0]), .dec_i(dec[0]), .count_o(stock1)
  );
  coin_stock_counter #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock2 (
    .clk(clk), .reset(reset), .inc_i(inc[1]), .dec_i(dec[1]), .count_o(stock2)
  );
  coin_stock_counter #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock3 (
    .clk(clk), .reset(reset), .inc_i(inc[2]), .dec_i(dec[2]), .count_o(stock3)
  );

  assign coin_out   = coin_q;
  assign coin_valid = coin_valid_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign req_ready  = req_ready_q;
  assign short_amt  = remaining_q;

endmodule

// File: tb/tb_coin_change_payout.sv
// Bench for coin_change_payout: greedy payout model feeding an expected-coin queue.
module tb_coin_change_payout;

  localparam int unsigned STOCK_W    = 4;
  localparam int unsigned INIT_STOCK = 4;
  localparam int          STOCK_MAX  = 15;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0;
  logic [3:0]          req_amount = 4'd0;
  logic                req_ready;
  logic [1:0]          coin_out;
  logic                coin_valid;
  logic                coin_ack = 1'b0;
  logic                done;
  logic                fault;
  logic [3:0]          short_amt;
  logic                refill_valid = 1'b0;
  logic [1:0]          refill_denom = 2'b00;
  logic [STOCK_W-1:0]  stock1, stock2, stock3;

  int checks = 0;
  int failures = 0;
  int mdl_stock [1:3];
  logic [1:0] exp_q [$];

  coin_change_payout #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .coin_out(coin_out), .coin_valid(coin_valid),
    .coin_ack(coin_ack), .done(done), .fault(fault), .short_amt(short_amt),
    .refill_valid(refill_valid), .refill_denom(refill_denom),
    .stock1(stock1), .stock2(stock2), .stock3(stock3)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) mdl_stock[k] = INIT_STOCK;
  endtask

  // Runs one payout; models greedy selection, scoreboards coins and completion.
  task automatic drive_payout(input string name, input logic [3:0] amt, input int ack_delay,
                              input bit chk_lat, input bit hold_req, input bit refill_on_ack);
    int rem, d, cyc, held, last_ack, exp_short;
    bit exp_fault, seen, finished;
    logic [1:0] cur, exp_coin;
    rem = amt; exp_fault = 1'b0; cur = 2'b00;
    while (rem > 0) begin
      d = 0;
      for (int k = 3; k >= 1; k--) if (d == 0 && k <= rem && mdl_stock[k] > 0) d = k;
      if (d == 0) begin exp_fault = 1'b1; break; end
      exp_q.push_back(2'(d));
      mdl_stock[d]--;
      rem -= d;
    end
    exp_short = rem;
    @(negedge clk);
    req_valid = 1'b1; req_amount = amt;
    cyc = 0; held = 0; last_ack = 0; seen = 1'b0; finished = 1'b0;
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold_req) req_valid = 1'b0;
      coin_ack = 1'b0; refill_valid = 1'b0;
      if (coin_valid) begin
        checks++;
        if (held == 0) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected_coin: got %b want none", name, coin_out);
          end else begin
            exp_coin = exp_q.pop_front();
            if (coin_out !== exp_coin) begin
              failures++;
              $display("FAIL %s coin: got %b want %b", name, coin_out, exp_coin);
            end
          end
          if (chk_lat && !seen) begin
            checks++;
            if (cyc !== 2) begin
              failures++;
              $display("FAIL %s first_coin_latency: got %0d want 2", name, cyc);
            end
          end
          seen = 1'b1; cur = coin_out;
        end else if (coin_out !== cur) begin
          failures++;
          $display("FAIL %s coin_stable: got %b want %b", name, coin_out, cur);
        end
        if (held == ack_delay) begin
          coin_ack = 1'b1; held = 0; last_ack = cyc;
          if (refill_on_ack) begin
            refill_valid = 1'b1; refill_denom = cur;
            if (mdl_stock[int'(cur)] < STOCK_MAX) mdl_stock[int'(cur)]++;
          end
        end else begin
          held++;
        end
      end
      if (done || fault) begin
        finished = 1'b1; req_valid = 1'b0;
        checks += 4;
        if (done !== !exp_fault || fault !== exp_fault) begin
          failures++;
          $display("FAIL %s outcome: got done=%b fault=%b want fault=%b", name, done, fault, exp_fault);
        end
        if (short_amt !== 4'(exp_short)) begin
          failures++;
          $display("FAIL %s short_amt: got %0d want %0d", name, short_amt, exp_short);
        end
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL %s coins_missing: got %0d left want 0", name, exp_q.size());
        end
        if (chk_lat && (cyc !== ((amt == 4'd0) ? 1 : last_ack + 1))) begin
          failures++;
          $display("FAIL %s done_latency: got %0d want %0d", name, cyc,
                   (amt == 4'd0) ? 1 : last_ack + 1);
        end
      end
    end
    coin_ack = 1'b0; refill_valid = 1'b0; req_valid = 1'b0;
    if (!finished) begin
      failures++;
      $display("FAIL %s timeout: got no done/fault want completion", name);
      exp_q.delete();
    end
  endtask

  task automatic check_stocks(input string name);
    checks++;
    if (stock1 !== STOCK_W'(mdl_stock[1]) || stock2 !== STOCK_W'(mdl_stock[2]) ||
        stock3 !== STOCK_W'(mdl_stock[3])) begin
      failures++;
      $display("FAIL %s stocks: got %0d/%0d/%0d want %0d/%0d/%0d", name, stock1, stock2, stock3,
               mdl_stock[1], mdl_stock[2], mdl_stock[3]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) mdl_stock[k] = INIT_STOCK;
    @(negedge clk); @(negedge clk);
    checks++;
    if (coin_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || fault !== 1'b0 ||
        coin_out !== 2'b00 || short_amt !== 4'd0) begin
      failures++;
      $display("FAIL reset outputs: got valid=%b ready=%b done=%b fault=%b coin=%b short=%0d want 0/1/0/0/00/0",
               coin_valid, req_ready, done, fault, coin_out, short_amt);
    end
    check_stocks("reset");
    reset = 1'b0;
  endtask

  task automatic test_ack_tied();
    apply_reset();
    drive_payout("amt6", 4'd6, 0, 1'b1, 1'b0, 1'b0);
    check_stocks("amt6");
    checks++;
    if (stock3 !== STOCK_W'(2)) begin
      failures++;
      $display("FAIL amt6 stock3: got %0d want 2", stock3);
    end
  endtask

  task automatic test_late_ack();
    apply_reset();
    drive_payout("amt5_late", 4'd5, 3, 1'b1, 1'b0, 1'b0);
    check_stocks("amt5_late");
  endtask

  task automatic test_greedy_fault();
    apply_reset();
    drive_payout("drain9", 4'd9, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive_payout("drain2", 4'd2, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_payout("drain1", 4'd1, 1, 1'b0, 1'b0, 1'b0);
    check_stocks("preset");
    drive_payout("greedy4", 4'd4, 0, 1'b0, 1'b0, 1'b0);
    check_stocks("greedy4");
  endtask

  task automatic test_zero_and_hold();
    apply_reset();
    drive_payout("amt0", 4'd0, 0, 1'b1, 1'b0, 1'b0);
    check_stocks("amt0");
    drive_payout("hold_req", 4'd3, 2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (coin_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL hold_req idle: got valid=%b ready=%b want 0/1", coin_valid, req_ready);
      end
    end
    check_stocks("hold_req");
  endtask

  task automatic test_refill();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      refill_valid = 1'b1; refill_denom = 2'b01;
      if (mdl_stock[1] < STOCK_MAX) mdl_stock[1]++;
    end
    @(negedge clk);
    refill_valid = 1'b1; refill_denom = 2'b00;
    @(negedge clk);
    refill_valid = 1'b0;
    check_stocks("refill_sat");
    checks++;
    if (stock1 !== STOCK_W'(15)) begin
      failures++;
      $display("FAIL refill_sat stock1: got %0d want 15", stock1);
    end
    drive_payout("refill_on_ack", 4'd1, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_stocks("refill_on_ack");
  endtask

  task automatic test_reset_mid_issue();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_amount = 4'd3;
    n = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
    end while (!coin_valid && n < 10);
    checks++;
    if (coin_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset reach_issue: got valid=%b want 1", coin_valid);
    end
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) mdl_stock[k] = INIT_STOCK;
    #1;
    checks++;
    if (coin_valid !== 1'b0 || coin_out !== 2'b00 || done !== 1'b0 || fault !== 1'b0 ||
        req_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset outputs: got valid=%b coin=%b done=%b fault=%b ready=%b want 0/00/0/0/1",
               coin_valid, coin_out, done, fault, req_ready);
    end
    check_stocks("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || fault !== 1'b0 || coin_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset after: got done=%b fault=%b valid=%b want 0/0/0", done, fault, coin_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack_tied();
    test_late_ack();
    test_greedy_fault();
    test_zero_and_hold();
    test_refill();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
